// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver, and later for a matching transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Receiver FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_PAR   = 3'd3;
  localparam state_t ST_STOP  = 3'd4;

  // Clocks per oversampling tick
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, held in phase while clr is high.
module uart_os_tick #(
  parameter int DIV = 108
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Down-counter reloads on clear or terminal count, so the first tick lands DIV clocks after clr falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= RELOAD;
    else if (clr || cnt == '0)
      cnt <= RELOAD;
    else
      cnt <= cnt - 1'b1;
  end

  assign tick = ~clr & (cnt == '0);

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with majority voting, error reporting and valid/ready output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a falling edge on the synchronised line
// START    | validating the start bit; majority 1 rejects it as a glitch
// DATA     | shifting DATA_BITS bits in, LSB first
// PAR      | checking the parity bit against the received data
// STOP     | checking stop bit(s); completes at the last vote sample
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int KW  = $clog2(OVERSAMPLE);

  localparam logic [KW-1:0] K_S0   = KW'(OVERSAMPLE/2 - 1);
  localparam logic [KW-1:0] K_S1   = KW'(OVERSAMPLE/2);
  localparam logic [KW-1:0] K_S2   = KW'(OVERSAMPLE/2 + 1);
  localparam logic [KW-1:0] K_LAST = KW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_os: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE must be 8 or 16");
  end

  logic                 rx_meta, rxs, rxs_q;
  state_t               state;
  logic [KW-1:0]        k;
  logic [3:0]           bit_cnt;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend, frame_pend;
  logic                 clr, tick, maj, at_vote, at_end;
  logic                 last_stop, done, fe_now, xfer, par_exp;

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; all idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign clr     = (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign maj     = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign at_vote = tick && (k == K_S2);
  assign at_end  = tick && (k == K_LAST);

  // Completion and handshake qualifiers; the third vote sample is taken live from rxs
  always_comb begin
    last_stop = (bit_cnt == LAST_STOP);
    done      = (state == ST_STOP) && at_vote && last_stop && rx_en;
    fe_now    = frame_pend | ~maj;
    xfer      = m_valid & m_ready;
    par_exp   = (PARITY == PARITY_ODD) ? ~(^shreg) : ^shreg;
  end

  // Receive FSM with tick index, vote samples, shift register and pending error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      bit_cnt    <= '0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      shreg      <= '0;
      par_pend   <= 1'b0;
      frame_pend <= 1'b0;
    end else if (state != ST_IDLE && !rx_en) begin
      state   <= ST_IDLE;
      k       <= '0;
      bit_cnt <= '0;
    end else begin
      if (tick) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
        if (k == K_S0) samp0 <= rxs;
        if (k == K_S1) samp1 <= rxs;
      end
      case (state)
        ST_IDLE: begin
          k       <= '0;
          bit_cnt <= '0;
          if (rx_en && rxs_q && !rxs) begin
            state      <= ST_START;
            par_pend   <= 1'b0;
            frame_pend <= 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && maj)
            state <= ST_IDLE;
          else if (at_end)
            state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_vote)
            shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (at_vote)
            par_pend <= (maj != par_exp);
          if (at_end)
            state <= ST_STOP;
        end
        ST_STOP: begin
          if (at_vote && !maj)
            frame_pend <= 1'b1;
          // Leaving at the vote rather than the window end lets the next start edge be caught early
          if (at_vote && last_stop)
            state <= ST_IDLE;
          else if (at_end)
            bit_cnt <= bit_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: deliver, drop with overrun, or drop with frame error; pulses last one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (xfer)
        m_valid <= 1'b0;
      if (done) begin
        if (fe_now) begin
          frame_err <= 1'b1;
        end else if (m_valid && !xfer) begin
          overrun <= 1'b1;
        end else begin
          m_data     <= shreg;
          m_valid    <= 1'b1;
          parity_err <= par_pend;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance and an even-parity instance share the serial line.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 864;  // 108 clocks per tick * 8 ticks per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_en0, rx_en1, m_ready0, m_ready1;
  logic [7:0] md [2];
  logic       mv [2];
  logic       pe [2];
  logic       fe [2];
  logic       ov [2];
  logic       bz [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en0), .rxd(rxd),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready0),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0])
  );

  uart_rx_os #(.PARITY(1)) dut_p (
    .clk(clk), .rst(rst), .rx_en(rx_en1), .rxd(rxd),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready1),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1])
  );

  // Event counters per instance, sampled on the falling edge
  logic       mon_clr;
  int         vcyc [2];
  int         perr [2];
  int         pv   [2];
  int         ferr [2];
  int         ovr  [2];
  logic [7:0] last [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_clr) begin
        vcyc[i] = 0; perr[i] = 0; pv[i] = 0; ferr[i] = 0; ovr[i] = 0; last[i] = 8'h00;
      end else begin
        if (mv[i]) begin vcyc[i]++; last[i] = md[i]; end
        if (pe[i]) perr[i]++;
        if (pe[i] && mv[i]) pv[i]++;
        if (fe[i]) ferr[i]++;
        if (ov[i]) ovr[i]++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Drive one frame at nominal baud; optional one-tick spike in data bit 3 and rx_en drop in data bit 4
  task automatic send_frame(input logic [7:0] data, input bit has_par, input logic par,
                            input logic stop, input bit spike, input int drop_bit);
    logic [10:0] bits;
    int          n;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (has_par) begin
      bits[9]  = par;
      bits[10] = stop;
      n        = 11;
    end else begin
      bits[9]  = stop;
      n        = 10;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        rxd = (spike && b == 4 && c >= 378 && c < 486) ? ~bits[b] : bits[b];
        if (b == drop_bit && c == 432) begin
          check("abort_busy_before", {31'd0, bz[0]}, 32'd1);
          rx_en0 = 1'b0;
          @(negedge clk);
          check("abort_busy_next_clock", {31'd0, bz[0]}, 32'd0);
        end
        @(negedge clk);
      end
    end
    rxd = 1'b1;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       stop;
    bit         spike;
    int         exp_v;
    logic [7:0] exp_d;
    int         exp_pe;
    int         exp_fe;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int s;
    //           sel data   par   stop  spk  v  exp_d  pe fe
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hA5, 0, 0};
    vecs[1] = '{0, 8'h5A, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 1};
    vecs[2] = '{1, 8'h3C, 1'b1, 1'b1, 1'b0, 1, 8'h3C, 1, 0};
    vecs[3] = '{1, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 8'h3C, 0, 0};

    rst = 1'b1; rxd = 1'b1; rx_en0 = 1'b1; rx_en1 = 1'b0;
    m_ready0 = 1'b1; m_ready1 = 1'b1; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_m_data",     {24'd0, md[0]}, 32'h00);
    check("reset_m_valid",    {31'd0, mv[0]}, 32'd0);
    check("reset_parity_err", {31'd0, pe[0]}, 32'd0);
    check("reset_frame_err",  {31'd0, fe[0]}, 32'd0);
    check("reset_overrun",    {31'd0, ov[0]}, 32'd0);
    check("reset_busy",       {31'd0, bz[0]}, 32'd0);
    check("reset_busy_par",   {31'd0, bz[1]}, 32'd0);
    rst = 1'b0;
    mon_clr = 1'b0;
    repeat (5) @(negedge clk);

    // Table: single frames with m_ready high
    for (int v = 0; v < 4; v++) begin
      s = vecs[v].sel;
      rx_en0 = (s == 0);
      rx_en1 = (s == 1);
      clear_mon();
      send_frame(vecs[v].data, s == 1, vecs[v].par, vecs[v].stop, vecs[v].spike, -1);
      repeat (200) @(negedge clk);
      check($sformatf("vec%0d_valid_cycles", v), vcyc[s], vecs[v].exp_v);
      if (vecs[v].exp_v > 0)
        check($sformatf("vec%0d_data", v), {24'd0, last[s]}, {24'd0, vecs[v].exp_d});
      check($sformatf("vec%0d_parity_err", v), perr[s], vecs[v].exp_pe);
      check($sformatf("vec%0d_parity_with_valid", v), pv[s], vecs[v].exp_pe);
      check($sformatf("vec%0d_frame_err", v), ferr[s], vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ovr[s], 0);
      check($sformatf("vec%0d_busy_idle", v), {31'd0, bz[s]}, 32'd0);
    end
    rx_en0 = 1'b1;
    rx_en1 = 1'b0;

    // Overrun: two back-to-back frames with nobody consuming
    m_ready0 = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (100) @(negedge clk);
    check("ovr_data_kept",  {24'd0, md[0]}, 32'h11);
    check("ovr_valid_held", {31'd0, mv[0]}, 32'd1);
    check("ovr_pulses",     ovr[0], 1);
    check("ovr_frame_err",  ferr[0], 0);
    m_ready0 = 1'b1;
    check("ovr_valid_before_ready_edge", {31'd0, mv[0]}, 32'd1);
    @(negedge clk);
    check("ovr_valid_falls", {31'd0, mv[0]}, 32'd0);

    // False start: a quarter-bit low pulse must be rejected
    clear_mon();
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy_in_start", {31'd0, bz[0]}, 32'd1);
    repeat (116) @(negedge clk);
    rxd = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_busy_back", {31'd0, bz[0]}, 32'd0);
    check("glitch_no_valid",  vcyc[0], 0);
    check("glitch_no_ferr",   ferr[0], 0);

    // Following frame, left unconsumed so the abort and reset cases have a word to preserve or clear
    m_ready0 = 1'b0;
    clear_mon();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (100) @(negedge clk);
    check("after_glitch_data",  {24'd0, md[0]}, 32'h81);
    check("after_glitch_valid", {31'd0, mv[0]}, 32'd1);

    // rx_en dropped in data bit 4 (frame bit 5)
    clear_mon();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    repeat (100) @(negedge clk);
    check("abort_data_kept",  {24'd0, md[0]}, 32'h81);
    check("abort_valid_kept", {31'd0, mv[0]}, 32'd1);
    check("abort_no_perr",    perr[0], 0);
    check("abort_no_ferr",    ferr[0], 0);
    check("abort_no_ovr",     ovr[0], 0);
    rx_en0 = 1'b1;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a start bit
    rxd = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, bz[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_m_valid", {31'd0, mv[0]}, 32'd0);
    check("rst_mid_m_data",  {24'd0, md[0]}, 32'h00);
    check("rst_mid_busy",    {31'd0, bz[0]}, 32'd0);
    check("rst_mid_flags",   {29'd0, pe[0], fe[0], ov[0]}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
